soc_system_debounced_pio: RTL
=============================

# soc_system_debounced_pio

Parametrised Avalon-MM input PIO for the HPS lightweight bridge. It succeeds the two-bit button PIO and accepts `WIDTH` inputs instead of two. Each input passes through a two-flop synchroniser and a per-bit debounce counter, and a software-selectable edge detector (rising, falling or both) runs on the debounced value. Captured edges are masked into a single level interrupt. The block serves the spider's push-buttons, limit switches and foot-contact sensors.

## Interface
- `WIDTH`, 4: number of input bits, legal range 1..16.
- `CNT_W`, 16: width of the debounce counters and of the reload register, legal range 1..32.
- `DEBOUNCE_DEFAULT`, 50000: reset value of the reload register (1 ms at 50 MHz), truncated to `CNT_W` bits.
- `IDLE_VALUE`, all zeros: `WIDTH`-bit reset value of the synchroniser flops and the debounced state.
- `RISE_RESET`, all ones: `WIDTH`-bit reset value of `rise_en`.
- `clk`  in  1  system clock; the only clock in the block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  3  Avalon-MM word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `in_port`  in  `WIDTH`  raw asynchronous inputs.
- `readdata`  out  32  registered read data.
- `irq`  out  1  level interrupt, active high.

## Operation
Register map. All reads are zero-extended to 32 bits. Writes to read-only or unused addresses are ignored.
- 0 `data` (RO): debounced state.
- 1 `raw` (RO): second synchroniser stage.
- 2 `irq_mask` (RW, `WIDTH` bits).
- 3 `edge_capture` (RW1C, `WIDTH` bits).
- 4 `rise_en` (RW, `WIDTH` bits).
- 5 `fall_en` (RW, `WIDTH` bits).
- 6 `reload` (RW, `CNT_W` bits).
- 7: reads 0.

Write strobe is `chipselect & ~write_n`.

Per-bit debounce. Compare the synchronised value `sync` with the debounced state `stable`:
- `sync == stable`: counter clears to 0.
- `sync != stable` and `cnt < reload`: counter increments.
- `sync != stable` and `cnt >= reload`: `stable <= sync`, counter clears, and a per-bit update strobe pulses.
- The comparison is `>=`, so lowering `reload` mid-count takes effect on the next edge with no lockup.
- `reload == 0` disables filtering: `stable` follows `sync` one edge later.
- The counter never wraps, because it is bounded by `reload`.

Edge capture:
- A bit's edge condition is `update & ((sync & rise_en) | (~sync & fall_en))`.
- When the edge condition holds, `edge_capture[i]` sets.
- A write to address 3 clears every bit where `writedata[i]` is 1.
- If a set and a clear hit the same bit on the same edge, the set wins, so no event is lost.
- Changing `rise_en` or `fall_en` never creates or removes captured bits.
- With both enables 0, a bit still debounces but never captures.

Interrupt:
- `irq = |(edge_capture & irq_mask)`, formed combinationally from flops only.
- Unmasking a bit that already holds a captured edge raises `irq` immediately.

Reset. Asserting `reset_n` low at any time, including mid-count, asynchronously forces:
- `readdata` = 0 and `irq` = 0;
- `irq_mask` = 0 and `edge_capture` = 0;
- sync flops and `stable` = `IDLE_VALUE`, counters = 0;
- `rise_en` = `RISE_RESET`, `fall_en` = 0, `reload` = `DEBOUNCE_DEFAULT`.

No edge is reported on reset release while `in_port` equals `IDLE_VALUE`.

## Timing
- `readdata` is registered every clock from the decoded `address`, independent of `chipselect`. Read latency is 1 cycle, with no wait states.
- Register writes take effect on the clock edge that samples the write.
- Input path, for `in_port[i]` changing before edge k and then holding:
  - `sync` changes at edge k+1.
  - `stable[i]` and `edge_capture[i]` update at edge k+2+R, where R = `reload`.
  - `irq` follows in the same cycle, if the bit is masked in.
- A glitch shorter than R+1 cycles at the `sync` stage causes no change, and its counter returns to 0.
- A clear write at edge j drops `irq` after edge j, unless a new edge set the bit on that same edge.

## Test plan
- Reset with `in_port`=0 and defaults -> all registers read their reset values, `irq`=0, `reload` reads 50000.
- R=3, rising only, `irq_mask`=1, drive `in_port[0]` 0->1 before edge 10 -> `data[0]` and `edge_capture[0]` read 1 from edge 15 and `irq` rises after edge 15. Repeat with `in_port[0]` high for 3 cycles only -> no change.
- `fall_en`=0x2, `rise_en`=0, R=0, toggle `in_port[1]` 1->0->1 -> one capture, on the falling edge. Enable both -> two captures, and the first W1C clears the bit.
- Write 0x1 to address 3 on the same edge as a new bit-0 edge -> `edge_capture[0]` stays 1 and `irq` stays high.
- R=100 with the counter at 60, write R=20 -> `stable` updates on the next edge.
- Assert `reset_n` with a count in progress and `edge_capture`=0xF -> `irq` drops asynchronously; after release, no capture occurs while `in_port` = `IDLE_VALUE`.

Source files
------------

// File: rtl/soc_system_debounced_pio.sv
// soc_system_debounced_pio
// Avalon-MM input PIO: per-bit two-flop synchroniser, reload-bounded debounce
// counter, selectable rising/falling edge capture and a masked level interrupt.
module soc_system_debounced_pio #(
    parameter int                WIDTH            = 4,
    parameter int                CNT_W            = 16,
    parameter int                DEBOUNCE_DEFAULT = 50000,
    parameter logic [WIDTH-1:0]  IDLE_VALUE       = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0]  RISE_RESET       = {WIDTH{1'b1}}
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_RAW    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_CAPT   = 3'd3;
    localparam logic [2:0] ADDR_RISE   = 3'd4;
    localparam logic [2:0] ADDR_FALL   = 3'd5;
    localparam logic [2:0] ADDR_RELOAD = 3'd6;

    localparam logic [CNT_W-1:0] RELOAD_RESET = CNT_W'(DEBOUNCE_DEFAULT);

    logic [WIDTH-1:0] sync_meta_r;
    logic [WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] stable_r;
    logic [CNT_W-1:0] cnt_r [WIDTH];
    logic [WIDTH-1:0] irq_mask_r;
    logic [WIDTH-1:0] edge_capture_r;
    logic [WIDTH-1:0] rise_en_r;
    logic [WIDTH-1:0] fall_en_r;
    logic [CNT_W-1:0] reload_r;
    logic [31:0]      readdata_r;

    logic             wr_s;
    logic [WIDTH-1:0] differ_s;
    logic [WIDTH-1:0] update_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] clear_s;
    logic [31:0]      rd_s;
    logic             unused_s;

    // Only the low bits of writedata reach registers; fold the rest away.
    assign unused_s = ^writedata;

    // Debounce decisions, edge qualification and write-one-to-clear decode.
    always_comb begin
        wr_s = chipselect & ~write_n;
        differ_s = {WIDTH{1'b0}};
        update_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            differ_s[i] = sync_r[i] ^ stable_r[i];
            // >= (not ==) so a reload lowered below a running count fires at once.
            update_s[i] = differ_s[i] & (cnt_r[i] >= reload_r);
        end
        edge_s = update_s & ((sync_r & rise_en_r) | (~sync_r & fall_en_r));
        if (wr_s && (address == ADDR_CAPT)) begin
            clear_s = writedata[WIDTH-1:0];
        end else begin
            clear_s = {WIDTH{1'b0}};
        end
    end

    // Read multiplexer; every register is zero-extended to the bus width.
    always_comb begin
        rd_s = 32'd0;
        case (address)
            ADDR_DATA:   rd_s = 32'(stable_r);
            ADDR_RAW:    rd_s = 32'(sync_r);
            ADDR_MASK:   rd_s = 32'(irq_mask_r);
            ADDR_CAPT:   rd_s = 32'(edge_capture_r);
            ADDR_RISE:   rd_s = 32'(rise_en_r);
            ADDR_FALL:   rd_s = 32'(fall_en_r);
            ADDR_RELOAD: rd_s = 32'(reload_r);
            default:     rd_s = 32'd0;
        endcase
    end

    // Input synchroniser, debounced state and per-bit debounce counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta_r <= IDLE_VALUE;
            sync_r      <= IDLE_VALUE;
            stable_r    <= IDLE_VALUE;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            sync_meta_r <= in_port;
            sync_r      <= sync_meta_r;
            stable_r    <= stable_r ^ update_s;
            for (int i = 0; i < WIDTH; i++) begin
                if (!differ_s[i] || update_s[i]) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1'b1);
                end
            end
        end
    end

    // Software-visible control registers and the edge-capture register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_r     <= {WIDTH{1'b0}};
            edge_capture_r <= {WIDTH{1'b0}};
            rise_en_r      <= RISE_RESET;
            fall_en_r      <= {WIDTH{1'b0}};
            reload_r       <= RELOAD_RESET;
        end else begin
            // A new edge on the same clock as its clear wins, so no event is lost.
            edge_capture_r <= (edge_capture_r & ~clear_s) | edge_s;
            if (wr_s) begin
                case (address)
                    ADDR_MASK:   irq_mask_r <= writedata[WIDTH-1:0];
                    ADDR_RISE:   rise_en_r  <= writedata[WIDTH-1:0];
                    ADDR_FALL:   fall_en_r  <= writedata[WIDTH-1:0];
                    ADDR_RELOAD: reload_r   <= writedata[CNT_W-1:0];
                    default: begin
                        irq_mask_r <= irq_mask_r;
                    end
                endcase
            end else begin
                reload_r <= reload_r;
            end
        end
    end

    // Registered read data, sampled every clock regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
        end else begin
            readdata_r <= rd_s;
        end
    end

    assign readdata = readdata_r;
    // Interrupt is a pure function of flops, so it drops asynchronously on reset.
    assign irq = |(edge_capture_r & irq_mask_r);

endmodule
